// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the round-robin grant arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  localparam int CNT_W = 8;

  function automatic int num_req(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: first set req bit at or above ptr, wrapping.
module rr_prio_enc
  import arb_pkg::*;
#(
  parameter int n = 3
) (
  input  logic [num_req(n)-1:0] req,
  input  logic [n-1:0]          ptr,
  output logic [n-1:0]          win,
  output logic                  any
);

  localparam int N = num_req(n);

  logic [n:0]   shl;
  logic [N-1:0] rot;
  logic [n-1:0] off;

  always_comb begin
    shl = (n+1)'(N) - {1'b0, ptr};
    rot = (req >> ptr) | (req << shl);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = n'(i);
    end
    // n-bit add wraps modulo N
    win = off + ptr;
    any = |req;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant and hold limit.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int n        = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [num_req(n)-1:0] req,
  output logic [num_req(n)-1:0] gnt,
  output logic [n-1:0]          gnt_idx,
  output logic                  gnt_valid
);

  localparam int N = num_req(n);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [n-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [n-1:0]     idx_q, idx_d;
  logic             vld_q, vld_d;

  logic [n-1:0] win;
  logic         any;
  logic         others;
  logic         owner_drop;
  logic         hold_hit;

  rr_prio_enc #(.n(n)) u_enc (
    .req (req),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  assign others     = |(req & ~gnt_q);
  assign owner_drop = ~req[idx_q];
  assign hold_hit   = (cnt_q == HOLD_LAST) && others;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          idx_d   = win;
          gnt_d   = N'(1) << win;
          vld_d   = 1'b1;
          ptr_d   = win + n'(1);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        unique case (1'b1)
          owner_drop || hold_hit: begin
            state_d = IDLE;
            idx_d   = '0;
            gnt_d   = '0;
            vld_d   = 1'b0;
            cnt_d   = '0;
          end
          default: begin
            if (cnt_q != HOLD_LAST)
              cnt_d = cnt_q + CNT_W'(1);
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (n=3, MAX_HOLD=4).
module tb_rr_grant_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int tests;
  int failed;

  rr_grant_arbiter #(.n(3), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int ei, input bit ev);
    logic [11:0] obs;
    logic [11:0] exp;
    logic [2:0]  idx;
    logic [7:0]  g;
    idx = ev ? ei[2:0] : 3'd0;
    g   = ev ? (8'd1 << idx) : 8'd0;
    exp = {g, idx, ev};
    obs = {gnt, gnt_idx, gnt_valid};
    tests++;
    assert (obs === exp) else begin
      failed++;
      $display("FAIL %s gnt=%h idx=%0d vld=%b required gnt=%h idx=%0d vld=%b",
               tag, gnt, gnt_idx, gnt_valid, g, idx, ev);
      $error("check %s", tag);
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    req    = 8'hFF;

    #2;
    chk("reset_pre_edge", 0, 0);
    tick();
    chk("reset_edge1", 0, 0);
    tick();
    chk("reset_edge2", 0, 0);
    req   = 8'h00;
    rst_n = 1'b1;
    tick();
    chk("idle_no_req", 0, 0);

    req = 8'b0000_0100;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("single_hold%0d", i), 2, 1);
    end
    req = 8'h00;
    tick();
    chk("single_release", 0, 0);

    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;

    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("rot_grant%0d", k), k % 8, 1);
      req = 8'hFF & ~(8'd1 << (k % 8));
      tick();
      chk($sformatf("rot_gap%0d", k), 0, 0);
      req = 8'hFF;
    end
    req = 8'h00;
    tick();
    chk("rot_end_idle", 0, 0);

    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;

    req = 8'b0000_0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold_a%0d", i), 0, 1);
    end
    tick();
    chk("hold_gap_a", 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold_b%0d", i), 1, 1);
    end
    tick();
    chk("hold_gap_b", 0, 0);
    tick();
    chk("hold_again0", 0, 1);

    req = 8'b0001_0000;
    tick();
    chk("sole_release0", 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("sole%0d", i), 4, 1);
    end

    req = 8'b0010_0000;
    tick();
    chk("pre5_release", 0, 0);
    tick();
    chk("grant5", 5, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_clear", 0, 0);
    req = 8'b0010_0001;
    tick();
    chk("reset_held_edge", 0, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_reset_idx0", 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout gnt=%h required finish", gnt);
    $fatal(1, "timeout");
  end

endmodule
